// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int unsigned DIV_RESTORING    = 0;
    localparam int unsigned DIV_NONRESTORING = 1;
    localparam int unsigned DIV_RADIX4       = 2;

    // Number of CALC cycles: radix-4 retires two quotient bits per cycle.
    function automatic int unsigned calc_iter(input int unsigned width, input int unsigned div_type);
        return (div_type == DIV_RADIX4) ? width / 2 : width;
    endfunction

endpackage

// File: rtl/divider_addsub.sv
// Add/subtract unit with carry out; carry-lookahead (4-bit groups) or ripple carry.
module divider_addsub #(
    parameter int unsigned WIDTH   = 33,
    parameter bit          USE_CLA = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign bx = b ^ {WIDTH{sub}};
    assign g  = a & bx;
    assign p  = a ^ bx;

    generate
        if (USE_CLA) begin : g_cla
            // Each carry inside a 4-bit group is a flat generate/propagate product of the group carry-in.
            always_comb begin
                logic t;
                logic pp;
                t    = 1'b0;
                pp   = 1'b1;
                c    = '0;
                c[0] = sub;
                for (int gb = 0; gb < int'(WIDTH); gb += 4) begin
                    for (int j = 0; j < 4; j++) begin
                        if (gb + j < int'(WIDTH)) begin
                            t  = 1'b0;
                            pp = 1'b1;
                            for (int k = j; k >= 0; k--) begin
                                t  = t | (g[gb+k] & pp);
                                pp = pp & p[gb+k];
                            end
                            c[gb+j+1] = t | (pp & c[gb]);
                        end
                    end
                end
            end
        end else begin : g_rca
            // Plain ripple chain.
            always_comb begin
                c    = '0;
                c[0] = sub;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    c[i+1] = g[i] | (p[i] & c[i]);
                end
            end
        end
    endgenerate

    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/divider_unit.sv
// Sequential signed/unsigned integer divider (restoring, non-restoring or radix-4).
// Optional feature macro: DIVIDER_DBZ_EN (early divide-by-zero completion).
module divider_unit
    import divider_pkg::*;
#(
    parameter int unsigned C_WIDTH  = 32,
    parameter int unsigned DIV_TYPE = 0,
    parameter bit          USE_CLA  = 1'b1
) (
    input  logic               ctl_clk,
    input  logic               reset,
    input  logic [C_WIDTH-1:0] a,
    input  logic [C_WIDTH-1:0] b,
    input  logic               signed_cal,
    input  logic               trigger,
    output logic [C_WIDTH-1:0] q,
    output logic [C_WIDTH-1:0] r,
    output logic               ready,
    output logic               done
);

    localparam int unsigned W    = C_WIDTH;
    localparam int unsigned PW   = (DIV_TYPE == DIV_RADIX4) ? C_WIDTH + 2 : C_WIDTH + 1;
    localparam int unsigned ITER = calc_iter(C_WIDTH, DIV_TYPE);
    localparam int unsigned CW   = $clog2(ITER);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    quo;
    logic [W-1:0]    dvsr;
    logic [PW-1:0]   prem;
    logic            q_neg;
    logic            r_neg;
`ifdef DIVIDER_DBZ_EN
    logic            dbz;
`endif

    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic [PW-1:0]   prem_nxt;
    logic [W-1:0]    quo_nxt;
    logic [W-1:0]    rem_fin;
    logic [W-1:0]    q_fin;
    logic [W-1:0]    r_fin;
    logic [PW-1:W]   prem_hi_unused;

    assign prem_hi_unused = prem[PW-1:W];

    // Operand magnitudes at capture.
    assign a_neg = signed_cal & a[W-1];
    assign b_neg = signed_cal & b[W-1];
    assign a_mag = a_neg ? W'(-a) : a;
    assign b_mag = b_neg ? W'(-b) : b;

    generate
        if (DIV_TYPE == DIV_RADIX4) begin : g_r4
            logic [PW-1:0] shifted;
            logic [PW-1:0] d1, d2, d3;
            logic [PW-1:0] s1, s2, s3;
            logic          c1, c2, c3;

            assign shifted = {prem[PW-3:0], quo[W-1 -: 2]};
            assign d1      = {2'b00, dvsr};
            assign d2      = {1'b0, dvsr, 1'b0};
            assign d3      = d1 + d2;

            divider_addsub #(.WIDTH(PW), .USE_CLA(USE_CLA)) u_as1 (.a(shifted), .b(d1), .sub(1'b1), .sum(s1), .cout(c1));
            divider_addsub #(.WIDTH(PW), .USE_CLA(USE_CLA)) u_as2 (.a(shifted), .b(d2), .sub(1'b1), .sum(s2), .cout(c2));
            divider_addsub #(.WIDTH(PW), .USE_CLA(USE_CLA)) u_as3 (.a(shifted), .b(d3), .sub(1'b1), .sum(s3), .cout(c3));

            // Pick the largest trial multiple that does not borrow.
            always_comb begin
                prem_nxt = shifted;
                quo_nxt  = {quo[W-3:0], 2'b00};
                if (c3) begin
                    prem_nxt = s3;
                    quo_nxt  = {quo[W-3:0], 2'b11};
                end else if (c2) begin
                    prem_nxt = s2;
                    quo_nxt  = {quo[W-3:0], 2'b10};
                end else if (c1) begin
                    prem_nxt = s1;
                    quo_nxt  = {quo[W-3:0], 2'b01};
                end
            end
            assign rem_fin = prem[W-1:0];
        end else if (DIV_TYPE == DIV_NONRESTORING) begin : g_nr
            logic [PW-1:0] shifted;
            logic [PW-1:0] op_a;
            logic [PW-1:0] sum;
            logic          sub;
            logic          fin;
            logic          cout_unused;

            // The single adder also performs the final negative-remainder correction in FINISH.
            assign fin     = (state == FINISH);
            assign shifted = {prem[PW-2:0], quo[W-1]};
            assign op_a    = fin ? prem : shifted;
            assign sub     = fin ? 1'b0 : ~prem[PW-1];

            divider_addsub #(.WIDTH(PW), .USE_CLA(USE_CLA)) u_as (.a(op_a), .b({1'b0, dvsr}), .sub(sub), .sum(sum), .cout(cout_unused));

            assign prem_nxt = sum;
            assign quo_nxt  = {quo[W-2:0], ~sum[PW-1]};
            assign rem_fin  = prem[PW-1] ? sum[W-1:0] : prem[W-1:0];
        end else begin : g_rs
            logic [PW-1:0] shifted;
            logic [PW-1:0] sum;
            logic          cout;

            assign shifted = {prem[PW-2:0], quo[W-1]};

            divider_addsub #(.WIDTH(PW), .USE_CLA(USE_CLA)) u_as (.a(shifted), .b({1'b0, dvsr}), .sub(1'b1), .sum(sum), .cout(cout));

            // No borrow means the trial subtraction is kept.
            assign prem_nxt = cout ? sum : shifted;
            assign quo_nxt  = {quo[W-2:0], cout};
            assign rem_fin  = prem[W-1:0];
        end
    endgenerate

    // Sign fix-up of the final magnitudes.
    always_comb begin
        q_fin = q_neg ? W'(-quo) : quo;
        r_fin = r_neg ? W'(-rem_fin) : rem_fin;
`ifdef DIVIDER_DBZ_EN
        if (dbz) begin
            q_fin = '1;
            r_fin = quo;
        end
`endif
    end

    // Control FSM and datapath registers.
    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            prem  <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            q     <= '0;
            r     <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
`ifdef DIVIDER_DBZ_EN
            dbz   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        ready <= 1'b0;
                        dvsr  <= b_mag;
                        quo   <= a_mag;
                        prem  <= '0;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        cnt   <= CW'(ITER - 1);
                        state <= CALC;
`ifdef DIVIDER_DBZ_EN
                        dbz   <= (b == '0);
                        if (b == '0) begin
                            quo   <= a;
                            state <= FINISH;
                        end
`endif
                    end
                end
                CALC: begin
                    prem <= prem_nxt;
                    quo  <= quo_nxt;
                    if (cnt == '0) begin
                        state <= FINISH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FINISH: begin
                    q     <= q_fin;
                    r     <= r_fin;
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// Bench for divider_unit: six variants (3 algorithms x 2 adder styles) run in lockstep.
module tb_divider_unit;

    localparam int NV = 6;
    localparam int W  = 32;
    localparam int MAX_WAIT = 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          s_in;
    logic          trig;
    logic [W-1:0]  q_o [NV];
    logic [W-1:0]  r_o [NV];
    logic          rdy [NV];
    logic          dn  [NV];

    int n_vec = 0;
    int n_err = 0;

    genvar gi;
    generate
        for (gi = 0; gi < NV; gi++) begin : g_dut
            divider_unit #(
                .C_WIDTH (W),
                .DIV_TYPE(gi % 3),
                .USE_CLA (gi < 3)
            ) u_dut (
                .ctl_clk   (clk),
                .reset     (rst_n),
                .a         (a_in),
                .b         (b_in),
                .signed_cal(s_in),
                .trigger   (trig),
                .q         (q_o[gi]),
                .r         (r_o[gi]),
                .ready     (rdy[gi]),
                .done      (dn[gi])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end
    endfunction

    function automatic int exp_latency(input int v, input logic [W-1:0] b);
`ifdef DIVIDER_DBZ_EN
        if (b == '0) return 1;
`endif
        return ((v % 3) == 2) ? 17 : 33;
    endfunction

    // One operation, checked on every variant; optional retrigger with new operands mid-CALC.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit glitch);
        logic [W-1:0] eq, er;
        int  done_at [NV];
        int  pulses  [NV];
        bit  check_vals;
        ref_div(a, b, s, eq, er);
        check_vals = 1'b1;
`ifndef DIVIDER_DBZ_EN
        if (b == '0) check_vals = 1'b0;
`endif
        for (int i = 0; i < NV; i++) begin
            done_at[i] = 0;
            pulses[i]  = 0;
        end
        @(negedge clk);
        for (int i = 0; i < NV; i++) chk($sformatf("ready_idle v%0d", i), W'(rdy[i]), W'(1));
        a_in = a;
        b_in = b;
        s_in = s;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        for (int i = 0; i < NV; i++) chk($sformatf("ready_busy v%0d", i), W'(rdy[i]), W'(0));
        for (int k = 1; k <= MAX_WAIT; k++) begin
            if (glitch && k == 5) begin
                a_in = $urandom;
                b_in = $urandom | 32'h1;
                s_in = ~s_in;
                trig = 1'b1;
            end
            if (glitch && k == 6) trig = 1'b0;
            @(negedge clk);
            for (int i = 0; i < NV; i++) begin
                if (dn[i]) begin
                    pulses[i]++;
                    if (done_at[i] == 0) begin
                        done_at[i] = k;
                        chk($sformatf("ready_done v%0d", i), W'(rdy[i]), W'(1));
                        if (check_vals) begin
                            chk($sformatf("q v%0d a=%0h b=%0h s=%0d", i, a, b, s), q_o[i], eq);
                            chk($sformatf("r v%0d a=%0h b=%0h s=%0d", i, a, b, s), r_o[i], er);
                        end
                    end
                end
            end
        end
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("latency v%0d", i), W'(done_at[i]), W'(exp_latency(i, b)));
            chk($sformatf("pulses v%0d", i), W'(pulses[i]), W'(1));
            if (check_vals) chk($sformatf("q_hold v%0d", i), q_o[i], eq);
        end
    endtask

    // Reset in the middle of CALC must clear outputs at once and suppress the pending done.
    task automatic reset_mid_calc();
        int pulses;
        @(negedge clk);
        a_in = 32'h7654_3210;
        b_in = 32'h0000_0013;
        s_in = 1'b0;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("rst_q v%0d", i), q_o[i], '0);
            chk($sformatf("rst_r v%0d", i), r_o[i], '0);
            chk($sformatf("rst_done v%0d", i), W'(dn[i]), W'(0));
            chk($sformatf("rst_ready v%0d", i), W'(rdy[i]), W'(1));
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            for (int i = 0; i < NV; i++) if (dn[i]) pulses++;
        end
        chk("no_done_after_reset", W'(pulses), W'(0));
        for (int i = 0; i < NV; i++) chk($sformatf("idle_after_reset v%0d", i), W'(rdy[i]), W'(1));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        rst_n = 1'b0;
        a_in  = '0;
        b_in  = '0;
        s_in  = 1'b0;
        trig  = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("reset_q v%0d", i), q_o[i], '0);
            chk($sformatf("reset_r v%0d", i), r_o[i], '0);
            chk($sformatf("reset_done v%0d", i), W'(dn[i]), W'(0));
            chk($sformatf("reset_ready v%0d", i), W'(rdy[i]), W'(1));
        end
        rst_n = 1'b1;

        run_op(32'h0000_000F, 32'h0000_0005, 1'b0, 1'b0);
        run_op(32'h0135_79BD, 32'h0024_68AC, 1'b0, 1'b0);
        run_op(32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 1'b0);
        run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'h0000_0003, 32'hFFFF_FFF0, 1'b0, 1'b0);
        run_op(32'h0123_4567, 32'h0000_0777, 1'b0, 1'b1);
        reset_mid_calc();

        for (int n = 0; n < 100; n++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: begin ra = $urandom; rb = W'($urandom_range(1, 15)); end
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
                2: begin ra = W'($urandom_range(0, 255)); rb = $urandom; end
                3: begin ra = $urandom; rb = -W'($urandom_range(1, 15)); end
                default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
            endcase
            if (rb == '0) rb = 32'h1;
            run_op(ra, rb, rs, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/divider_unit.md
# divider_unit

Sequential integer divider computing quotient and remainder of two C_WIDTH-bit operands, unsigned or two's-complement signed, selected per operation. It sits on the synthesizer control clock as a shared arithmetic unit, started by a one-cycle trigger and reporting completion with a done pulse. The iteration algorithm and the adder style are compile-time selectable; all variants give bit-identical results.

## Interface
- C_WIDTH, 32: operand/result width (even, ≥4).
- DIV_TYPE, 0: 0 = radix-2 restoring, 1 = radix-2 non-restoring, 2 = radix-4 restoring (two quotient bits per cycle).
- USE_CLA, 1: 1 = subtract/add through carry-lookahead adder; 0 = ripple-carry adder.
- ctl_clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a  in  C_WIDTH  dividend.
- b  in  C_WIDTH  divisor.
- signed_cal  in  1  1 = signed operands, 0 = unsigned.
- trigger  in  1  start request.
- q  out  C_WIDTH  quotient (registered).
- r  out  C_WIDTH  remainder (registered).
- ready  out  1  high when idle and able to accept trigger.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE: ready=1. Trigger high at an edge captures a, b and signed_cal, then enters CALC with ready=0.
- Signed capture: operands converted to magnitudes; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a).
- CALC: ITER iterations, one per cycle. ITER = C_WIDTH for DIV_TYPE 0/1, C_WIDTH/2 for DIV_TYPE 2. Partial remainder is C_WIDTH+1 bits wide (C_WIDTH+2 for radix-4).
- Non-restoring: the final negative remainder is corrected in FINISH.
- FINISH: applies remainder correction and sign fix-up, registers q and r, pulses done, sets ready=1 and returns to IDLE.
- Unsigned: q = a / b, r = a mod b.
- Signed: quotient truncates toward zero; r has the sign of a (or is 0); a = q*b + r.
- Signed overflow, most-negative / -1: q = most-negative, r = 0.
- Trigger while not ready is ignored. Operand changes after capture have no effect.
- q and r hold their value until the next completion.
- Reset, at any time including mid-operation: q=0, r=0, done=0, ready=1, state IDLE, and any in-flight operation is discarded.

## Timing
- Latency: done and the new q/r appear ITER+1 cycles after the capturing edge.
  - C_WIDTH=32, DIV_TYPE 0/1: 33 cycles.
  - C_WIDTH=32, DIV_TYPE 2: 17 cycles.
- done is high for exactly one cycle. ready rises on the same edge.
- Back-to-back: trigger in the first ready cycle after done starts the next operation.

## Configuration
- DIVIDER_DBZ_EN defined:
  - b == 0 is detected at capture and skips CALC.
  - done comes 1 cycle after capture, with q = all ones and r = a (raw a, regardless of signed_cal).
- DIVIDER_DBZ_EN undefined:
  - No detection; full latency.
  - q/r for b == 0 are implementation-defined, but ready/done still complete normally.

## Structure
- Package divider_pkg:
  - State enum (IDLE/CALC/FINISH).
  - DIV_TYPE constants DIV_RESTORING=0, DIV_NONRESTORING=1, DIV_RADIX4=2.
  - ITER computation function.
- Sub-module divider_addsub:
  - Parameterised width, with add/sub control and carry out.
  - CLA or ripple implementation chosen by USE_CLA.
  - Instantiated once per iteration step: one for radix-2, three for radix-4 trial multiples.

## Test plan
- Unsigned: a=0x0000000F, b=0x00000005, all three DIV_TYPEs with USE_CLA=1 -> q=3, r=0, done one cycle; ready high again.
- Unsigned: a=0x013579BD, b=0x002468AC -> q=0x00000008, r=0x0012345D. DIV_TYPE 0/1 done exactly 33 cycles after capture; DIV_TYPE 2 after 17.
- Signed: a=5, b=0xFFFFFFFD -> q=0xFFFFFFFF, r=2. Then a=0xFFFFFFF9, b=2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Then a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0.
- Divide by zero with DIVIDER_DBZ_EN: a=0x1234, b=0 -> done 1 cycle after capture, q=0xFFFFFFFF, r=0x1234.
- Robustness:
  - Trigger pulsed again mid-CALC with new operands -> ignored; original result is delivered.
  - Reset asserted mid-CALC -> q=r=0, done=0, ready=1 immediately; no later done pulse.
- Sweep: random operands, both signedness modes, USE_CLA 0/1, all DIV_TYPEs -> results match a reference model and are identical across variants.
